// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction fetch front end.
package inst_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetchEntry_t;

    function automatic logic [31:0] alignPc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Small circular buffer of {pc, inst} entries with synchronous flush.
module inst_fifo
    import inst_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetchEntry_t   wrData,
    output fetchEntry_t   rdData,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetchEntry_t   mem [DEPTH];
    logic [PW-1:0] rdPtr, wrPtr;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= nextPtr(wrPtr);
            if (pop)  rdPtr <= nextPtr(rdPtr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wrPtr] <= wrData;
    end

    assign rdData = mem[rdPtr];

endmodule

// File: rtl/inst_fetch.sv
// Fetch front end: PC, credit-limited in-order memory requests, response buffering and redirect handling.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int            CW  = $clog2(DEPTH + 1);
    localparam logic [CW:0]   CAP = (CW + 1)'(DEPTH);

    logic [31:0]   fetchPc, rspPc;
    logic [CW-1:0] outstanding, drop, count, outstandingNext;
    logic [CW:0]   inUse;
    logic          accept, rspIn, push, pop;
    fetchEntry_t   wrEntry, head;

    // Credits cover both in-flight requests and buffered words, so the FIFO never overflows.
    assign inUse          = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid = !rst && !redirect_valid && (inUse < CAP);
    assign imem_req_addr  = fetchPc;
    assign accept         = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rspIn           = imem_rsp_valid && (outstanding != '0);
    assign push            = rspIn && (drop == '0) && !redirect_valid;
    assign outstandingNext = outstanding + CW'(accept) - CW'(rspIn);

    assign inst_valid = (count != '0) && !redirect_valid;
    assign pop        = inst_valid && inst_ready;
    assign inst       = inst_valid ? head.inst : NOP_INST;
    assign inst_pc    = inst_valid ? head.pc : '0;

    assign wrEntry = '{pc: rspPc, inst: imem_rsp_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchPc     <= RESET_PC;
            rspPc       <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstandingNext;
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old stream.
                fetchPc <= alignPc(redirect_pc);
                rspPc   <= alignPc(redirect_pc);
                drop    <= outstandingNext;
            end else begin
                if (accept) fetchPc <= fetchPc + 32'd4;
                if (push)   rspPc   <= rspPc + 32'd4;
                if (rspIn && (drop != '0)) drop <= drop - CW'(1);
            end
        end
    end

    inst_fifo #(.DEPTH(DEPTH)) uFifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .flush  (redirect_valid),
        .wrData (wrEntry),
        .rdData (head),
        .count  (count)
    );

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch front end and producer of the 32-bit instruction word consumed by the core's instruction decoder.
- Holds the PC and issues in-order requests to instruction memory.
- Buffers returned words in a small FIFO and presents them, with their PC, over a valid/ready interface.
- Handles redirects (branch/jump) by flushing the buffer and discarding in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 2, instruction buffer entries; also the max of (outstanding + buffered)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  32  word address of request (bits [1:0] always 0)
imem_rsp_valid  input  1  response data valid; responses return in request order, ≥1 cycle after accept
imem_rsp_data  input  32  returned instruction word
redirect_valid  input  1  one-cycle pulse: discard everything, restart at redirect_pc
redirect_pc  input  32  new fetch address
inst_valid  output  1  inst/inst_pc valid toward decoder
inst_ready  input  1  decoder consumes inst this cycle
inst  output  32  instruction word (32'h0000_0013 NOP when inst_valid=0)
inst_pc  output  32  address of inst

Behaviour:
- Reset: fetch_pc=RESET_PC, buffer empty, outstanding=0, drop=0. Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst=NOP, inst_pc=0.
- Request rule:
  - imem_req_valid = !rst && !redirect_valid && (outstanding + count < DEPTH).
  - imem_req_addr = fetch_pc.
  - On accept (valid & ready): fetch_pc += 4 (wraps mod 2^32), outstanding += 1.
  - First request is presented in the first cycle after rst deasserts.
- Response rule: each imem_rsp_valid decrements outstanding.
  - If drop>0: data discarded, drop -= 1.
  - Else: {data, pc} pushed into the FIFO tail. The pc is tracked by a separate rsp_pc counter that advances by 4 per kept response.
  - The credit rule guarantees no overflow. A response arriving with outstanding=0 is a protocol error and is ignored.
- Output:
  - inst_valid = (count>0) && !redirect_valid; inst/inst_pc come from the FIFO head.
  - Pop on inst_valid & inst_ready. Push and pop may occur in the same cycle.
  - No bypass: a response becomes visible the cycle after it arrives. Minimum accept-to-inst_valid latency is 2 cycles with 1-cycle memory.
- Redirect (redirect_valid=1), with priority over everything in that cycle:
  - fetch_pc and rsp_pc := {redirect_pc[31:2], 2'b00}.
  - FIFO cleared; no pop occurs.
  - drop := outstanding_next, i.e. count after this cycle's accept/response updates, excluding a response being dropped now.
  - No request is issued in the redirect cycle; the first request at the new PC goes out the next cycle.
  - A redirect while drop>0 accumulates correctly because the new drop is simply the current in-flight count.
- Back-to-back redirects: the last one wins.
- Decoder stall (inst_ready=0) with a full FIFO: requests stop when outstanding + count = DEPTH and resume the cycle after a pop.
- Async rst mid-operation: all state returns to reset values immediately. Responses for pre-reset requests are not expected; the memory is reset together with the core.

Decomposition:
- Shared header gets `RESET_PC_DEFAULT 32'h0000_0000` and `NOP_INST 32'h0000_0013`.
- One sub-module, inst_fifo: parameterized DEPTH, 64-bit entries {pc, inst}, push/pop/flush, count output, synchronous flush, async reset. The fetch top holds the PC, rsp_pc, outstanding/drop counters and the request logic.

Test Plan:
1. Reset release, 1-cycle memory, inst_ready=1 → requests at 0x0, 0x4, 0x8…; inst_valid first high 2 cycles after the first accept; inst_pc sequence 0x0, 0x4, 0x8 with matching data.
2. inst_ready=0 for 10 cycles, DEPTH=2 → exactly 2 requests accepted, then imem_req_valid=0. Raise inst_ready → words at 0x0, 0x4 delivered, fetch resumes at 0x8.
3. Memory latency 3 cycles, redirect to 0x100 with 2 requests outstanding → both responses dropped, next request addr=0x100, first inst_pc=0x100.
4. redirect_pc=0x203 → imem_req_addr=0x200.
5. imem_req_ready low for 5 cycles → imem_req_valid held, addr stable at 0x0, no PC advance.
6. rst asserted mid-stream with a full FIFO → inst_valid=0 and imem_req_valid=0 immediately; after release the first request is at RESET_PC.
